dma_priority_arbiter: RTL and testbench

Parametrised channel-priority and hold-request sequencer for the DMA controller. It generalises the fixed 4-channel priority logic to NUM_CH channels and adds a rotating-priority mode, per-channel masking, demand-mode channel retention and EOP abort. It sits between the channel request pins (DREQ), the timing-control state machine and the CPU hold handshake (HRQ/HLDA). All outputs are registered.

---
 rtl/dma_priority_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dma_priority_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter
// Channel-priority and hold-request sequencer for an NUM_CH-channel DMA
// controller. Picks a winner among eligible requests (fixed or rotating
// priority), runs the HRQ/HLDA handshake, keeps demand-mode channels on the
// bus and honours EOP and HLDA-drop aborts. All outputs are registered
// decodes of the sequencer state, so they follow the state by one cycle.
module dma_priority_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic              priorityType,
    input  logic [NUM_CH-1:0] demandMode,
    input  logic              HLDA,
    input  logic              EOP_N,
    input  logic              serviceDone,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic [CH_W-1:0]   activeCh,
    output logic              busy
);

    localparam logic [3:0] ST_IDLE    = 4'b0001;
    localparam logic [3:0] ST_REQ     = 4'b0010;
    localparam logic [3:0] ST_GRANT   = 4'b0100;
    localparam logic [3:0] ST_RELEASE = 4'b1000;

    localparam logic [CH_W:0]     NUM_CH_V = (CH_W + 1)'(NUM_CH);
    localparam logic [CH_W:0]     ONE_V    = (CH_W + 1)'(1);
    localparam logic [NUM_CH-1:0] ONE_CH   = (NUM_CH)'(1);

    // First set bit of elig scanning upward from start, wrapping at NUM_CH.
    // The request vector is doubled so the wrap becomes a plain shift.
    function automatic logic [CH_W-1:0] pick_winner(
        input logic [NUM_CH-1:0] elig,
        input logic [CH_W-1:0]   start
    );
        logic [2*NUM_CH-1:0] rot;
        logic [CH_W:0]       off;
        logic [CH_W:0]       idx;
        logic                found;
        logic [CH_W-1:0]     res;
        rot   = {elig, elig} >> start;
        off   = {(CH_W + 1){1'b0}};
        found = 1'b0;
        res   = {CH_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (rot[0] && !found) begin
                idx = {1'b0, start} + off;
                if (idx >= NUM_CH_V) begin
                    idx = idx - NUM_CH_V;
                end else begin
                    idx = idx;
                end
                res   = idx[CH_W-1:0];
                found = 1'b1;
            end else begin
                found = found;
            end
            rot = rot >> 1;
            off = off + ONE_V;
        end
        return res;
    endfunction

    logic [3:0]        state_r;
    logic [3:0]        state_s;
    logic [CH_W-1:0]   act_r;
    logic [CH_W-1:0]   act_s;
    logic [CH_W-1:0]   ptr_r;
    logic [CH_W-1:0]   ptr_s;
    logic [CH_W-1:0]   ptr_eff_s;
    logic [CH_W-1:0]   ptr_after_s;
    logic [CH_W:0]     ptr_inc_s;
    logic [NUM_CH-1:0] eligible_s;
    logic [NUM_CH-1:0] retain_vec_s;
    logic [CH_W-1:0]   winner_s;
    logic              keep_s;

    assign eligible_s   = DREQ & ~maskReg;
    assign ptr_eff_s    = priorityType ? ptr_r : {CH_W{1'b0}};
    assign winner_s     = pick_winner(eligible_s, ptr_eff_s);
    // Demand retention needs the active channel still requesting and unmasked.
    assign retain_vec_s = (demandMode & eligible_s) >> act_r;
    assign keep_s       = retain_vec_s[0];

    // Pointer value that makes the served channel the lowest priority.
    always_comb begin
        ptr_inc_s = {1'b0, act_r} + ONE_V;
        if (ptr_inc_s >= NUM_CH_V) begin
            ptr_after_s = {CH_W{1'b0}};
        end else begin
            ptr_after_s = ptr_inc_s[CH_W-1:0];
        end
    end

    // Sequencer next-state, winner latch and rotating-pointer update.
    always_comb begin
        state_s = state_r;
        act_s   = act_r;
        ptr_s   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (eligible_s != {NUM_CH{1'b0}}) begin
                    act_s   = winner_s;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (eligible_s == {NUM_CH{1'b0}}) begin
                    state_s = ST_IDLE;
                end else if (HLDA) begin
                    act_s   = winner_s;
                    state_s = ST_GRANT;
                end else begin
                    act_s   = winner_s;
                    state_s = ST_REQ;
                end
            end
            ST_GRANT: begin
                if (!HLDA) begin
                    // Bus taken back: abandon the tenure, pointer untouched.
                    state_s = ST_IDLE;
                end else if (!EOP_N || (serviceDone && !keep_s)) begin
                    state_s = ST_RELEASE;
                    if (priorityType) begin
                        ptr_s = ptr_after_s;
                    end else begin
                        ptr_s = ptr_r;
                    end
                end else begin
                    state_s = ST_GRANT;
                end
            end
            ST_RELEASE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                act_s   = {CH_W{1'b0}};
            end
        endcase
    end

    // Sequencer state, latched winner and priority pointer.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_IDLE;
            act_r   <= {CH_W{1'b0}};
            ptr_r   <= {CH_W{1'b0}};
        end else begin
            state_r <= state_s;
            act_r   <= act_s;
            ptr_r   <= ptr_s;
        end
    end

    // Registered output decode; DACK is also withheld the moment HLDA drops.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            HRQ      <= 1'b0;
            DACK     <= {NUM_CH{1'b0}};
            activeCh <= {CH_W{1'b0}};
            busy     <= 1'b0;
        end else begin
            HRQ      <= (state_r == ST_REQ) || (state_r == ST_GRANT);
            if ((state_r == ST_GRANT) && HLDA) begin
                DACK <= ONE_CH << act_r;
            end else begin
                DACK <= {NUM_CH{1'b0}};
            end
            activeCh <= act_r;
            busy     <= (state_r != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: three instances (4, 1 and 8 channels) share
// one stimulus bus. Directed scenarios check fixed expectations; a
// cycle-level reference model built from the arbitration rules runs
// alongside every cycle and the randomized scenario compares against it.
module tb_dma_priority_arbiter;

    localparam int P_IDLE  = 0;
    localparam int P_REQ   = 1;
    localparam int P_GRANT = 2;
    localparam int P_REL   = 3;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [7:0] dreq, mask, demand;
    logic       prio, hlda, eop_n, sd;

    logic       hrq4, hrq1, hrq8, busy4, busy1, busy8;
    logic [3:0] dack4;
    logic [0:0] dack1;
    logic [7:0] dack8;
    logic [1:0] act4;
    logic [0:0] act1;
    logic [2:0] act8;

    logic       o_hrq [3];
    logic [7:0] o_dack[3];
    int         o_act [3];
    logic       o_busy[3];

    int         m_phase[3], m_ch[3], m_ptr[3];
    bit         e_hrq[3], e_busy[3];
    logic [7:0] e_dack[3];
    int         e_act[3];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    dma_priority_arbiter #(.NUM_CH(4)) u_ch4 (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(dreq[3:0]), .maskReg(mask[3:0]),
        .priorityType(prio), .demandMode(demand[3:0]), .HLDA(hlda), .EOP_N(eop_n),
        .serviceDone(sd), .HRQ(hrq4), .DACK(dack4), .activeCh(act4), .busy(busy4));

    dma_priority_arbiter #(.NUM_CH(1)) u_ch1 (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(dreq[0:0]), .maskReg(mask[0:0]),
        .priorityType(prio), .demandMode(demand[0:0]), .HLDA(hlda), .EOP_N(eop_n),
        .serviceDone(sd), .HRQ(hrq1), .DACK(dack1), .activeCh(act1), .busy(busy1));

    dma_priority_arbiter #(.NUM_CH(8)) u_ch8 (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(dreq), .maskReg(mask),
        .priorityType(prio), .demandMode(demand), .HLDA(hlda), .EOP_N(eop_n),
        .serviceDone(sd), .HRQ(hrq8), .DACK(dack8), .activeCh(act8), .busy(busy8));

    assign o_hrq[0]  = hrq4;
    assign o_hrq[1]  = hrq1;
    assign o_hrq[2]  = hrq8;
    assign o_dack[0] = {4'b0000, dack4};
    assign o_dack[1] = {7'b0000000, dack1};
    assign o_dack[2] = dack8;
    assign o_act[0]  = int'(act4);
    assign o_act[1]  = int'(act1);
    assign o_act[2]  = int'(act8);
    assign o_busy[0] = busy4;
    assign o_busy[1] = busy1;
    assign o_busy[2] = busy8;

    function automatic int nch_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 8);
    endfunction

    function automatic int lowbit(input int v);
        return v & (-v);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_phase[k] = P_IDLE; m_ch[k] = 0; m_ptr[k] = 0;
            e_hrq[k] = 1'b0; e_dack[k] = 8'd0; e_act[k] = 0; e_busy[k] = 1'b0;
        end
    endtask

    // One clock of the reference model, using the inputs seen at this edge.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int n, elig, pe, win, c;
            bit keep;
            n    = nch_of(k);
            elig = int'({24'd0, dreq & ~mask}) & ((1 << n) - 1);
            pe   = prio ? m_ptr[k] : 0;
            win  = -1;
            for (int i = 0; i < n; i++) begin
                c = (pe + i) % n;
                if (win < 0 && ((elig >> c) & 1) == 1) win = c;
            end
            keep = (((int'({24'd0, demand}) & elig) >> m_ch[k]) & 1) == 1;
            e_hrq[k]  = (m_phase[k] == P_REQ) || (m_phase[k] == P_GRANT);
            e_dack[k] = (m_phase[k] == P_GRANT && hlda) ? 8'(1 << m_ch[k]) : 8'd0;
            e_act[k]  = m_ch[k];
            e_busy[k] = (m_phase[k] != P_IDLE);
            case (m_phase[k])
                P_IDLE: if (win >= 0) begin m_ch[k] = win; m_phase[k] = P_REQ; end
                P_REQ: begin
                    if (win < 0) m_phase[k] = P_IDLE;
                    else begin
                        m_ch[k] = win;
                        if (hlda) m_phase[k] = P_GRANT;
                    end
                end
                P_GRANT: begin
                    if (!hlda) m_phase[k] = P_IDLE;
                    else if (!eop_n || (sd && !keep)) begin
                        m_phase[k] = P_REL;
                        if (prio) m_ptr[k] = (m_ch[k] + 1) % n;
                    end
                end
                default: m_phase[k] = P_IDLE;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic quiet_inputs();
        dreq = 8'd0; mask = 8'd0; demand = 8'd0; prio = 1'b0;
        hlda = 1'b1; eop_n = 1'b1; sd = 1'b0;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        repeat (2) @(negedge CLK);
        model_reset();
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        quiet_inputs();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            n_assert += 4;
            if (o_hrq[k] !== 1'b0) begin n_fail++; $display("FAIL reset_hrq inst%0d got %b want 0", k, o_hrq[k]); end
            if (o_dack[k] !== 8'd0) begin n_fail++; $display("FAIL reset_dack inst%0d got %b want 0", k, o_dack[k]); end
            if (o_act[k] !== 0) begin n_fail++; $display("FAIL reset_act inst%0d got %0d want 0", k, o_act[k]); end
            if (o_busy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy inst%0d got %b want 0", k, o_busy[k]); end
        end
    endtask

    task automatic test_fixed();
        quiet_inputs();
        for (int d = 0; d < 16; d++) begin
            dreq = 8'(d);
            tick();
            n_assert++;
            if (hrq4 !== 1'b0) begin n_fail++; $display("FAIL fixed_hrq_early d=%0d got %b want 0", d, hrq4); end
            tick();
            n_assert += 2;
            if (hrq4 !== (d != 0)) begin n_fail++; $display("FAIL fixed_hrq d=%0d got %b want %b", d, hrq4, d != 0); end
            if (hrq1 !== ((d & 1) != 0)) begin n_fail++; $display("FAIL fixed_hrq1 d=%0d got %b want %b", d, hrq1, (d & 1) != 0); end
            tick();
            n_assert += 3;
            if (dack4 !== 4'(lowbit(d))) begin n_fail++; $display("FAIL fixed_dack4 d=%0d got %b want %b", d, dack4, 4'(lowbit(d))); end
            if (dack8 !== 8'(lowbit(d))) begin n_fail++; $display("FAIL fixed_dack8 d=%0d got %b want %b", d, dack8, 8'(lowbit(d))); end
            if (dack1 !== 1'(d & 1)) begin n_fail++; $display("FAIL fixed_dack1 d=%0d got %b want %b", d, dack1, 1'(d & 1)); end
            sd = 1'b1; dreq = 8'd0;
            tick();
            sd = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic test_rotating();
        quiet_inputs();
        do_reset();
        prio = 1'b1; dreq = 8'hFF;
        for (int j = 0; j < 5; j++) begin
            tick(); tick(); tick();
            n_assert += 3;
            if (dack4 !== 4'(1 << (j % 4))) begin n_fail++; $display("FAIL rot_dack4 step%0d got %b want %b", j, dack4, 4'(1 << (j % 4))); end
            if (dack8 !== 8'(1 << j)) begin n_fail++; $display("FAIL rot_dack8 step%0d got %b want %b", j, dack8, 8'(1 << j)); end
            if (dack1 !== 1'b1) begin n_fail++; $display("FAIL rot_dack1 step%0d got %b want 1", j, dack1); end
            sd = 1'b1;
            tick();
            sd = 1'b0;
            tick();
            n_assert++;
            if (hrq4 !== 1'b0) begin n_fail++; $display("FAIL rot_release_hrq step%0d got %b want 0", j, hrq4); end
        end
        // Back-to-back tenure: HRQ stays low until three edges after the pulse.
        tick();
        n_assert++;
        if (hrq4 !== 1'b0) begin n_fail++; $display("FAIL b2b_hrq_gap got %b want 0", hrq4); end
        tick();
        n_assert++;
        if (hrq4 !== 1'b1) begin n_fail++; $display("FAIL b2b_hrq_rise got %b want 1", hrq4); end
        dreq = 8'd0; sd = 1'b1;
        tick(); tick();
        sd = 1'b0;
        tick(); tick(); tick();
        prio = 1'b0;
    endtask

    task automatic test_masking();
        quiet_inputs();
        dreq = 8'h03; mask = 8'h01;
        tick(); tick(); tick();
        n_assert += 2;
        if (dack4 !== 4'b0010) begin n_fail++; $display("FAIL mask_dack4 got %b want 0010", dack4); end
        if (dack1 !== 1'b0) begin n_fail++; $display("FAIL mask_dack1 got %b want 0", dack1); end
        sd = 1'b1; dreq = 8'd0;
        tick();
        sd = 1'b0; mask = 8'd0;
        tick(); tick();
        hlda = 1'b0; dreq = 8'h03;
        tick(); tick();
        n_assert++;
        if (hrq4 !== 1'b1) begin n_fail++; $display("FAIL mask_req_hrq got %b want 1", hrq4); end
        mask = 8'h03;
        tick(); tick();
        n_assert += 2;
        if (hrq4 !== 1'b0) begin n_fail++; $display("FAIL mask_drop_hrq got %b want 0", hrq4); end
        if (busy4 !== 1'b0) begin n_fail++; $display("FAIL mask_drop_busy got %b want 0", busy4); end
        quiet_inputs();
        tick(); tick();
    endtask

    task automatic test_demand();
        quiet_inputs();
        demand = 8'h04; dreq = 8'h04;
        tick(); tick(); tick();
        n_assert++;
        if (dack4 !== 4'b0100) begin n_fail++; $display("FAIL demand_first got %b want 0100", dack4); end
        for (int r = 0; r < 3; r++) begin
            sd = 1'b1;
            tick();
            sd = 1'b0;
            n_assert++;
            if (dack4 !== 4'b0100) begin n_fail++; $display("FAIL demand_hold_a pulse%0d got %b want 0100", r, dack4); end
            tick();
            n_assert++;
            if (dack4 !== 4'b0100) begin n_fail++; $display("FAIL demand_hold_b pulse%0d got %b want 0100", r, dack4); end
        end
        dreq = 8'd0;
        tick();
        n_assert++;
        if (dack4 !== 4'b0100) begin n_fail++; $display("FAIL demand_dreq_drop got %b want 0100", dack4); end
        sd = 1'b1;
        tick();
        sd = 1'b0;
        tick();
        n_assert += 2;
        if (dack4 !== 4'b0000) begin n_fail++; $display("FAIL demand_release_dack got %b want 0000", dack4); end
        if (hrq4 !== 1'b0) begin n_fail++; $display("FAIL demand_release_hrq got %b want 0", hrq4); end
        tick();
        n_assert++;
        if (busy4 !== 1'b0) begin n_fail++; $display("FAIL demand_idle_busy got %b want 0", busy4); end
        demand = 8'd0;
    endtask

    task automatic test_eop_abort();
        quiet_inputs();
        do_reset();
        prio = 1'b1; dreq = 8'h0F;
        tick(); tick(); tick();
        n_assert++;
        if (dack4 !== 4'b0001) begin n_fail++; $display("FAIL eop_first got %b want 0001", dack4); end
        eop_n = 1'b0;
        tick();
        eop_n = 1'b1;
        tick();
        n_assert += 2;
        if (dack4 !== 4'b0000) begin n_fail++; $display("FAIL eop_dack got %b want 0000", dack4); end
        if (hrq4 !== 1'b0) begin n_fail++; $display("FAIL eop_hrq got %b want 0", hrq4); end
        tick(); tick(); tick();
        n_assert++;
        if (dack4 !== 4'b0010) begin n_fail++; $display("FAIL eop_ptr_adv got %b want 0010", dack4); end
        hlda = 1'b0; sd = 1'b1;
        tick();
        hlda = 1'b1; sd = 1'b0;
        tick();
        n_assert += 2;
        if (dack4 !== 4'b0000) begin n_fail++; $display("FAIL abort_dack got %b want 0000", dack4); end
        if (hrq4 !== 1'b0) begin n_fail++; $display("FAIL abort_hrq got %b want 0", hrq4); end
        tick(); tick();
        n_assert++;
        if (dack4 !== 4'b0010) begin n_fail++; $display("FAIL abort_no_ptr got %b want 0010", dack4); end
        dreq = 8'd0; sd = 1'b1;
        tick();
        sd = 1'b0;
        tick(); tick();
        prio = 1'b0;
    endtask

    task automatic test_reset_mid();
        quiet_inputs();
        dreq = 8'h01;
        tick(); tick(); tick();
        #2;
        RESET_N = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_assert += 4;
            if (o_dack[k] !== 8'd0) begin n_fail++; $display("FAIL midreset_dack inst%0d got %b want 0", k, o_dack[k]); end
            if (o_hrq[k] !== 1'b0) begin n_fail++; $display("FAIL midreset_hrq inst%0d got %b want 0", k, o_hrq[k]); end
            if (o_busy[k] !== 1'b0) begin n_fail++; $display("FAIL midreset_busy inst%0d got %b want 0", k, o_busy[k]); end
            if (o_act[k] !== 0) begin n_fail++; $display("FAIL midreset_act inst%0d got %0d want 0", k, o_act[k]); end
        end
        model_reset();
        dreq = 8'd0;
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic test_random();
        quiet_inputs();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 3) == 0) dreq = 8'($urandom);
            if ($urandom_range(0, 7) == 0) mask = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 15) == 0) demand = 8'($urandom);
            if ($urandom_range(0, 31) == 0) prio = ~prio;
            hlda  = ($urandom_range(0, 9) != 0);
            eop_n = ($urandom_range(0, 15) != 0);
            sd    = ($urandom_range(0, 3) == 0);
            tick();
            for (int k = 0; k < 3; k++) begin
                n_assert += 6;
                if (o_hrq[k] !== e_hrq[k]) begin n_fail++; $display("FAIL rand_hrq cyc%0d inst%0d got %b want %b", cyc, k, o_hrq[k], e_hrq[k]); end
                if (o_dack[k] !== e_dack[k]) begin n_fail++; $display("FAIL rand_dack cyc%0d inst%0d got %b want %b", cyc, k, o_dack[k], e_dack[k]); end
                if (o_act[k] !== e_act[k]) begin n_fail++; $display("FAIL rand_act cyc%0d inst%0d got %0d want %0d", cyc, k, o_act[k], e_act[k]); end
                if (o_busy[k] !== e_busy[k]) begin n_fail++; $display("FAIL rand_busy cyc%0d inst%0d got %b want %b", cyc, k, o_busy[k], e_busy[k]); end
                if ($countones(o_dack[k]) > 1) begin n_fail++; $display("FAIL rand_onehot cyc%0d inst%0d got %b want at most one bit", cyc, k, o_dack[k]); end
                if (o_dack[k] != 8'd0 && o_hrq[k] !== 1'b1) begin n_fail++; $display("FAIL rand_dack_wo_hrq cyc%0d inst%0d dack %b hrq %b want hrq 1", cyc, k, o_dack[k], o_hrq[k]); end
            end
        end
        quiet_inputs();
        tick(); tick(); tick();
    endtask

    initial begin
        quiet_inputs();
        RESET_N = 1'b0;
        model_reset();
        test_reset();
        test_fixed();
        test_rotating();
        test_masking();
        test_demand();
        test_eop_abort();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
